// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: DEPTH-entry first-word-fall-through packet queue between pipeline stages,
// with valid/ready handshakes on both sides and a synchronous flush.
module pipe_stage_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_packet,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_packet,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;

    // in_ready comes from registered count only, so out_ready never reaches it
    assign in_ready   = count != CW'(DEPTH);
    assign out_valid  = count != '0;
    assign push       = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready & ~flush;
    assign out_packet = out_valid ? mem[rd_ptr] : '0;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_packet;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    end
endmodule
